// File: rtl/beh_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : beh_sync_fifo
//  Purpose  : Single-clock behavioural FIFO buffering DSIZE-bit words between
//             a producer and a consumer, with full/empty flags. Writes while
//             full and reads while empty are silently dropped.
//  Ports    : wclk    - clock, all state updates on rising edge
//             wrst_n  - synchronous active-low reset
//             winc    - write request
//             wdata   - write data [DSIZE-1:0]
//             rinc    - read request (pop)
//             rdata   - word at head of FIFO (fall-through, combinational)
//             wfull   - FIFO holds DEPTH words
//             rempty  - FIFO holds no words
//  Revision : 1.0 - initial release
// ============================================================================
module beh_sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty
);

    localparam int c_DEPTH = 2 ** (ASIZE - 1);

    logic [DSIZE-1:0] r_mem [c_DEPTH];
    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;

    logic [ASIZE-2:0] w_waddr;
    logic [ASIZE-2:0] w_raddr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_waddr = r_wptr[ASIZE-2:0];
    assign w_raddr = r_rptr[ASIZE-2:0];

    // Equal pointers mean empty; equal addresses with differing wrap bits
    // mean the writer is a full lap ahead of the reader.
    assign rempty = (r_wptr == r_rptr);
    assign wfull  = (r_wptr[ASIZE-1] != r_rptr[ASIZE-1]) && (w_waddr == w_raddr);

    // Gating on the current flags is what makes a simultaneous write/read
    // while full degrade to read-only, and while empty to write-only.
    assign w_wr_en = winc && !wfull;
    assign w_rd_en = rinc && !rempty;

    assign rdata = r_mem[w_raddr];

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            // Storage is cleared so rdata is a defined zero straight after reset.
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[w_waddr] <= wdata;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_beh_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_beh_sync_fifo
//  Purpose  : Self-checking bench for beh_sync_fifo. A queue-based reference
//             model tracks FIFO contents; directed scenarios plus randomized
//             traffic are compared against flags and head-of-queue data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_beh_sync_fifo;

    localparam int c_DEPTH = 8;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;

    int n_chk;
    int n_err;

    logic [7:0] model_q [$];

    beh_sync_fifo #(
        .DSIZE (8),
        .ASIZE (4)
    ) u_dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .winc   (winc),
        .wdata  (wdata),
        .rinc   (rinc),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one clock cycle, advance the model with the pre-edge occupancy,
    // then compare flags and head data shortly after the edge.
    task automatic step(input logic rst_n, input logic w, input logic [7:0] d, input logic r);
        bit do_wr;
        bit do_rd;
        wrst_n = rst_n;
        winc   = w;
        wdata  = d;
        rinc   = r;
        @(posedge wclk);
        if (!rst_n) begin
            model_q.delete();
        end else begin
            do_rd = r && (model_q.size() > 0);
            do_wr = w && (model_q.size() < c_DEPTH);
            if (do_rd) void'(model_q.pop_front());
            if (do_wr) model_q.push_back(d);
        end
        #1;
        check_val("rempty", {31'd0, rempty}, {31'd0, model_q.size() == 0});
        check_val("wfull", {31'd0, wfull}, {31'd0, model_q.size() == c_DEPTH});
        if (model_q.size() > 0) check_val("rdata", {24'd0, rdata}, {24'd0, model_q[0]});
    endtask

    int next_wr;

    initial begin
        n_chk  = 0;
        n_err  = 0;
        wrst_n = 1'b0;
        winc   = 1'b0;
        wdata  = 8'h00;
        rinc   = 1'b0;

        // Reset held two edges with a write pending: nothing stored, rdata zero.
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b1, 8'hBB, 1'b0);
        check_val("rst_rdata", {24'd0, rdata}, 32'd0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check_val("post_rst_rdata", {24'd0, rdata}, 32'd0);

        // Fill 1..8, overflow write of 9, then drain.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
        check_val("fill_full", {31'd0, wfull}, 32'd1);
        step(1'b1, 1'b1, 8'd9, 1'b0);
        check_val("ovf_head", {24'd0, rdata}, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        check_val("drain_empty", {31'd0, rempty}, 32'd1);

        // Underflow reads then a single write that falls through.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check_val("ff_0x55", {24'd0, rdata}, 32'h55);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Concurrent write/read at steady occupancy of three.
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
        for (int i = 4; i <= 7; i++) step(1'b1, 1'b1, 8'(i), 1'b1);
        check_val("conc_head", {24'd0, rdata}, 32'd5);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Wrap: stream 1..20 with random interleaved reads, then drain.
        next_wr = 1;
        for (int i = 0; i < 200 && (next_wr <= 20 || model_q.size() > 0); i++) begin
            if (next_wr <= 20 && $urandom_range(0, 3) != 0 && model_q.size() < c_DEPTH) begin
                step(1'b1, 1'b1, 8'(next_wr), ($urandom_range(0, 3) == 0));
                next_wr++;
            end else begin
                step(1'b1, 1'b0, 8'h00, 1'b1);
            end
        end
        check_val("wrap_done", {31'd0, rempty}, 32'd1);

        // Full with simultaneous write/read: only the read happens.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
        step(1'b1, 1'b1, 8'd99, 1'b1);
        check_val("fb_notfull", {31'd0, wfull}, 32'd0);
        check_val("fb_head", {24'd0, rdata}, 32'd2);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Mid-operation reset with five words held.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check_val("midrst_empty", {31'd0, rempty}, 32'd1);
        step(1'b1, 1'b1, 8'hA1, 1'b0);
        step(1'b1, 1'b1, 8'hA2, 1'b0);
        check_val("midrst_new", {24'd0, rdata}, 32'hA1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 99) < ((i < 300) ? 60 : 40)),
                 8'($urandom),
                 ($urandom_range(0, 99) < ((i < 300) ? 40 : 60)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
